// File: rtl/snow64_scalar_lane_access_unit_pkg.sv
// Shared types and size codes for the scalar lane access unit.
// The typedefs describe the default 256-bit LAR configuration.
package PkgSnow64ScalarLaneAccess;

  localparam int unsigned DEF_LAR_WIDTH    = 256;
  localparam int unsigned DEF_SCALAR_WIDTH = 64;
  localparam int unsigned DEF_OFFSET_WIDTH = $clog2(DEF_LAR_WIDTH / 8);

  typedef logic [DEF_LAR_WIDTH-1:0]    LarData;
  typedef logic [DEF_SCALAR_WIDTH-1:0] ScalarData;
  typedef logic [DEF_OFFSET_WIDTH-1:0] DataOffset;
  typedef logic [DEF_LAR_WIDTH/8-1:0]  ByteEn;

  typedef enum logic [1:0] {
    DtUnsgnInt = 2'd0,
    DtSgnInt   = 2'd1,
    DtBFloat16 = 2'd2,
    DtReserved = 2'd3
  } DataType;

  typedef enum logic [1:0] {
    IntTypSz8  = 2'd0,
    IntTypSz16 = 2'd1,
    IntTypSz32 = 2'd2,
    IntTypSz64 = 2'd3
  } IntTypeSize;

  localparam logic [1:0] SIZE_CODE_8  = 2'd0;
  localparam logic [1:0] SIZE_CODE_16 = 2'd1;
  localparam logic [1:0] SIZE_CODE_32 = 2'd2;
  localparam logic [1:0] SIZE_CODE_64 = 2'd3;

  typedef struct packed {
    logic       mode;
    LarData     lar;
    ScalarData  scalar;
    DataType    data_type;
    IntTypeSize int_type_size;
    DataOffset  data_offset;
  } PortIn_ScalarLaneAccess;

  typedef struct packed {
    ScalarData scalar;
    LarData    lar;
    ByteEn     byte_en;
    logic      misaligned;
    logic      bad_type;
  } PortOut_ScalarLaneAccess;

endpackage

// File: rtl/snow64_scalar_lane_access_unit_shifter.sv
// Maps an element size code and raw byte offset to the aligned byte mask,
// the matching bit shift and the misalignment flag.
module snow64_scalar_lane_shifter
  import PkgSnow64ScalarLaneAccess::*;
#(
  parameter  int unsigned LAR_WIDTH    = 256,
  localparam int unsigned OFFSET_WIDTH = $clog2(LAR_WIDTH / 8),
  localparam int unsigned BYTES        = LAR_WIDTH / 8
) (
  input  logic [1:0]              size_code,
  input  logic [OFFSET_WIDTH-1:0] offset,
  output logic [BYTES-1:0]        byte_en,
  output logic [OFFSET_WIDTH+2:0] bit_shift,
  output logic                    misaligned
);

  logic [OFFSET_WIDTH-1:0] low_mask;
  logic [OFFSET_WIDTH-1:0] aligned;
  logic [7:0]              elem_mask;

  always_comb begin
    low_mask  = '0;
    elem_mask = 8'h01;
    unique case (size_code)
      SIZE_CODE_8:  begin low_mask = OFFSET_WIDTH'(0); elem_mask = 8'h01; end
      SIZE_CODE_16: begin low_mask = OFFSET_WIDTH'(1); elem_mask = 8'h03; end
      SIZE_CODE_32: begin low_mask = OFFSET_WIDTH'(3); elem_mask = 8'h0F; end
      default:      begin low_mask = OFFSET_WIDTH'(7); elem_mask = 8'hFF; end
    endcase
    aligned    = offset & ~low_mask;
    misaligned = |(offset & low_mask);
    byte_en    = BYTES'(elem_mask) << aligned;
    bit_shift  = {aligned, 3'b000};
  end

endmodule

// File: rtl/snow64_scalar_lane_access_unit.sv
// Two-stage extract/inject engine for LAR lines with valid/ready on both sides.
// S1 holds the decoded request, S2 holds the shifted or merged result.
module snow64_scalar_lane_access_unit
  import PkgSnow64ScalarLaneAccess::*;
#(
  parameter  int unsigned LAR_WIDTH    = 256,
  parameter  int unsigned SCALAR_WIDTH = 64,
  localparam int unsigned OFFSET_WIDTH = $clog2(LAR_WIDTH / 8)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [LAR_WIDTH-1:0]    in_lar,
  input  logic [SCALAR_WIDTH-1:0] in_scalar,
  input  logic [1:0]              in_data_type,
  input  logic [1:0]              in_int_type_size,
  input  logic [OFFSET_WIDTH-1:0] in_data_offset,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SCALAR_WIDTH-1:0] out_scalar,
  output logic [LAR_WIDTH-1:0]    out_lar,
  output logic [LAR_WIDTH/8-1:0]  out_byte_en,
  output logic                    out_misaligned,
  output logic                    out_bad_type
);

  localparam int unsigned BYTES       = LAR_WIDTH / 8;
  localparam int unsigned SHIFT_WIDTH = OFFSET_WIDTH + 3;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic                   dec_bad;
  logic [1:0]             dec_size;
  logic [BYTES-1:0]       dec_byte_en;
  logic [SHIFT_WIDTH-1:0] dec_shift;
  logic                   dec_misaligned;

  // Reserved types fall back to the 8-bit decode so misalignment is always 0.
  always_comb begin
    dec_bad  = (in_data_type == DtReserved);
    dec_size = in_int_type_size;
    if (in_data_type == DtBFloat16) dec_size = SIZE_CODE_16;
    else if (dec_bad)               dec_size = SIZE_CODE_8;
  end

  snow64_scalar_lane_shifter #(.LAR_WIDTH(LAR_WIDTH)) u_shifter (
    .size_code (dec_size),
    .offset    (in_data_offset),
    .byte_en   (dec_byte_en),
    .bit_shift (dec_shift),
    .misaligned(dec_misaligned)
  );

  logic                    s1_valid;
  logic                    s1_mode;
  logic                    s1_signed;
  logic                    s1_bad;
  logic                    s1_misaligned;
  logic [1:0]              s1_size;
  logic [LAR_WIDTH-1:0]    s1_lar;
  logic [SCALAR_WIDTH-1:0] s1_scalar;
  logic [BYTES-1:0]        s1_byte_en;
  logic [SHIFT_WIDTH-1:0]  s1_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_mode       <= 1'b0;
      s1_signed     <= 1'b0;
      s1_bad        <= 1'b0;
      s1_misaligned <= 1'b0;
      s1_size       <= '0;
      s1_lar        <= '0;
      s1_scalar     <= '0;
      s1_byte_en    <= '0;
      s1_shift      <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode       <= in_mode;
        s1_signed     <= (in_data_type == DtSgnInt);
        s1_bad        <= dec_bad;
        s1_misaligned <= dec_misaligned;
        s1_size       <= dec_size;
        s1_lar        <= in_lar;
        s1_scalar     <= in_scalar;
        s1_byte_en    <= dec_bad ? '0 : dec_byte_en;
        s1_shift      <= dec_shift;
      end
    end
  end

  logic [63:0]          raw;
  logic [63:0]          elem;
  logic [LAR_WIDTH-1:0] bit_mask;
  logic [LAR_WIDTH-1:0] merged;

  always_comb begin
    raw = 64'(s1_lar >> s1_shift);
    unique case (s1_size)
      SIZE_CODE_8:  elem = s1_signed ? {{56{raw[7]}},  raw[7:0]}  : {56'd0, raw[7:0]};
      SIZE_CODE_16: elem = s1_signed ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
      SIZE_CODE_32: elem = s1_signed ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
      default:      elem = raw;
    endcase
    bit_mask = '0;
    for (int unsigned i = 0; i < BYTES; i++) bit_mask[8*i +: 8] = {8{s1_byte_en[i]}};
    // An empty mask (reserved type) leaves the line untouched.
    merged = (s1_lar & ~bit_mask) | ((LAR_WIDTH'(s1_scalar) << s1_shift) & bit_mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_scalar     <= '0;
      out_lar        <= '0;
      out_byte_en    <= '0;
      out_misaligned <= 1'b0;
      out_bad_type   <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_scalar     <= (s1_mode || s1_bad) ? '0 : SCALAR_WIDTH'(elem);
        out_lar        <= s1_mode ? merged : s1_lar;
        out_byte_en    <= s1_byte_en;
        out_misaligned <= s1_misaligned;
        out_bad_type   <= s1_bad;
      end
    end
  end

endmodule

// File: tb/tb_snow64_scalar_lane_access_unit.sv
// Bench for the scalar lane access unit: directed table, randomized traffic
// against a byte-level reference model, a stalled stream and reset flush.
module tb_snow64_scalar_lane_access_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [255:0] in_lar;
  logic [63:0]  in_scalar;
  logic [1:0]   in_data_type;
  logic [1:0]   in_int_type_size;
  logic [4:0]   in_data_offset;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_scalar;
  logic [255:0] out_lar;
  logic [31:0]  out_byte_en;
  logic         out_misaligned;
  logic         out_bad_type;

  snow64_scalar_lane_access_unit #(.LAR_WIDTH(256), .SCALAR_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_lar(in_lar), .in_scalar(in_scalar), .in_data_type(in_data_type),
    .in_int_type_size(in_int_type_size), .in_data_offset(in_data_offset),
    .out_valid(out_valid), .out_ready(out_ready), .out_scalar(out_scalar),
    .out_lar(out_lar), .out_byte_en(out_byte_en),
    .out_misaligned(out_misaligned), .out_bad_type(out_bad_type)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         mode;
    logic [255:0] lar;
    logic [63:0]  scalar;
    logic [1:0]   dt;
    logic [1:0]   sz;
    logic [4:0]   off;
  } req_t;

  typedef struct {
    logic [63:0]  scalar;
    logic [255:0] lar;
    logic [31:0]  be;
    logic         mis;
    logic         bad;
  } res_t;

  typedef struct {
    req_t r;
    res_t e;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;
  logic p1v = 1'b0, p2v = 1'b0;
  res_t p1, p2;
  req_t idle;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-level view: pick the element's bytes out of (or into) the line.
  function automatic res_t model(input req_t r);
    res_t        res;
    int unsigned e, off;
    res.lar = r.lar; res.scalar = '0; res.be = '0; res.mis = 1'b0; res.bad = 1'b0;
    if (r.dt == 2'd3) begin
      res.bad = 1'b1;
      return res;
    end
    e   = (r.dt == 2'd2) ? 2 : (1 << r.sz);
    res.mis = (r.off % e) != 0;
    off = r.off - (r.off % e);
    for (int unsigned k = 0; k < e; k++) begin
      res.be[off+k] = 1'b1;
      if (r.mode) res.lar[8*(off+k) +: 8] = r.scalar[8*k +: 8];
      else        res.scalar[8*k +: 8] = r.lar[8*(off+k) +: 8];
    end
    if (!r.mode && r.dt == 2'd1 && e < 8 && res.scalar[8*e-1])
      res.scalar = res.scalar | ({64{1'b1}} << (8*e));
    return res;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.mode = 1'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) r.lar[32*i +: 32] = $urandom();
    r.scalar = {$urandom(), $urandom()};
    r.dt  = 2'($urandom_range(0, 3));
    r.sz  = 2'($urandom_range(0, 3));
    r.off = 5'($urandom_range(0, 31));
    return r;
  endfunction

  // One clock: drive at the falling edge, check before the rising edge,
  // then advance the transaction-level pipeline model.
  task automatic cycle(input req_t r, input logic v, input logic rdy, output logic acc);
    logic adv;
    in_valid = v; in_mode = r.mode; in_lar = r.lar; in_scalar = r.scalar;
    in_data_type = r.dt; in_int_type_size = r.sz; in_data_offset = r.off;
    out_ready = rdy;
    #1;
    adv = !p2v || rdy;
    check("in_ready", in_ready, adv);
    check("out_valid", out_valid, p2v);
    if (p2v) begin
      check("out_scalar", out_scalar, p2.scalar);
      check("out_lar", out_lar, p2.lar);
      check("out_byte_en", out_byte_en, p2.be);
      check("out_misaligned", out_misaligned, p2.mis);
      check("out_bad_type", out_bad_type, p2.bad);
      if (rdy) n_out++;
    end
    acc = v && adv;
    if (adv) begin
      p2v = p1v; p2 = p1;
      p1v = v;
      if (v) p1 = model(r);
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1; p1v = 1'b0; p2v = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_scalar", out_scalar, 64'd0);
    check("rst_out_lar", out_lar, 256'd0);
    check("rst_out_byte_en", out_byte_en, 32'd0);
    check("rst_out_misaligned", out_misaligned, 1'b0);
    check("rst_out_bad_type", out_bad_type, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t         tbl[6];
    logic [255:0] base;
    logic         acc;
    req_t         r, stream[8];
    logic         pending;
    int           sent, cyc, out_base;

    idle = '{mode: 1'b0, lar: '0, scalar: '0, dt: 2'd0, sz: 2'd0, off: 5'd0};
    in_valid = 1'b0; in_mode = 1'b0; in_lar = '0; in_scalar = '0;
    in_data_type = '0; in_int_type_size = '0; in_data_offset = '0; out_ready = 1'b0;
    base = {8{32'h5A3C_96E1}};

    // signed 8-bit extract, off 5, byte 0x80
    tbl[0].r = '{mode: 1'b0, lar: base, scalar: 64'h0, dt: 2'd1, sz: 2'd0, off: 5'd5};
    tbl[0].r.lar[47:40] = 8'h80;
    tbl[0].e = '{scalar: 64'hFFFF_FFFF_FFFF_FF80, lar: tbl[0].r.lar, be: 32'h0000_0020, mis: 1'b0, bad: 1'b0};
    // unsigned 32-bit inject, off 6 rounds down to 4
    tbl[1].r = '{mode: 1'b1, lar: base, scalar: 64'h1122_3344_AABB_CCDD, dt: 2'd0, sz: 2'd2, off: 5'd6};
    tbl[1].e = '{scalar: 64'h0, lar: base, be: 32'h0000_00F0, mis: 1'b1, bad: 1'b0};
    tbl[1].e.lar[63:32] = 32'hAABB_CCDD;
    // BFloat16 extract at the top of the line; size field ignored
    tbl[2].r = '{mode: 1'b0, lar: base, scalar: 64'h0, dt: 2'd2, sz: 2'd3, off: 5'd30};
    tbl[2].r.lar[255:240] = 16'h3F80;
    tbl[2].e = '{scalar: 64'h3F80, lar: tbl[2].r.lar, be: 32'hC000_0000, mis: 1'b0, bad: 1'b0};
    // reserved type inject: line passes through, no bytes enabled
    tbl[3].r = '{mode: 1'b1, lar: base, scalar: 64'hDEAD_BEEF_0BAD_F00D, dt: 2'd3, sz: 2'd2, off: 5'd7};
    tbl[3].e = '{scalar: 64'h0, lar: base, be: 32'h0, mis: 1'b0, bad: 1'b1};
    // unsigned 64-bit extract, off 8
    tbl[4].r = '{mode: 1'b0, lar: base, scalar: 64'h0, dt: 2'd0, sz: 2'd3, off: 5'd8};
    tbl[4].e = '{scalar: 64'h5A3C_96E1_5A3C_96E1, lar: base, be: 32'h0000_FF00, mis: 1'b0, bad: 1'b0};
    // signed 16-bit extract, off 1 rounds down to 0, negative
    tbl[5].r = '{mode: 1'b0, lar: base, scalar: 64'h0, dt: 2'd1, sz: 2'd1, off: 5'd1};
    tbl[5].e = '{scalar: 64'hFFFF_FFFF_FFFF_96E1, lar: base, be: 32'h0000_0003, mis: 1'b1, bad: 1'b0};

    rst_n = 1'b0;
    do_reset(2);

    // Directed vectors: accept, one more edge, result must be presented.
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].r, 1'b1, 1'b1, acc);
      check("tbl_accept", acc, 1'b1);
      cycle(idle, 1'b0, 1'b1, acc);
      #1;
      check("tbl_valid_latency", out_valid, 1'b1);
      check("tbl_scalar", out_scalar, tbl[i].e.scalar);
      check("tbl_lar", out_lar, tbl[i].e.lar);
      check("tbl_byte_en", out_byte_en, tbl[i].e.be);
      check("tbl_misaligned", out_misaligned, tbl[i].e.mis);
      check("tbl_bad_type", out_bad_type, tbl[i].e.bad);
      cycle(idle, 1'b0, 1'b1, acc);
    end

    // Randomized traffic with random back-pressure; requests held until taken.
    pending = 1'b0;
    r = idle;
    for (int i = 0; i < 400; i++) begin
      if (!pending) begin
        r = rand_req();
        pending = ($urandom_range(0, 3) != 0);
      end
      cycle(r, pending, 1'($urandom_range(0, 3) != 0), acc);
      if (acc) pending = 1'b0;
    end
    repeat (4) cycle(idle, 1'b0, 1'b1, acc);

    // Back-to-back stream of 8 with a 3-cycle consumer stall mid-stream.
    for (int i = 0; i < 8; i++) stream[i] = rand_req();
    out_base = n_out;
    sent = 0;
    cyc  = 0;
    while (sent < 8 && cyc < 100) begin
      cycle(stream[sent], 1'b1, !(cyc >= 5 && cyc < 8), acc);
      if (cyc >= 5 && cyc < 8) check("stall_in_ready_low", in_ready, 1'b0);
      if (acc) sent++;
      cyc++;
    end
    check("stream_all_sent", sent, 8);
    check("stream_cycles", cyc, 11);
    repeat (4) cycle(idle, 1'b0, 1'b1, acc);
    check("stream_results", n_out - out_base, 8);

    // Reset with two requests in flight: neither may emerge.
    out_base = n_out;
    cycle(stream[0], 1'b1, 1'b1, acc);
    cycle(stream[1], 1'b1, 1'b1, acc);
    do_reset(1);
    repeat (4) cycle(idle, 1'b0, 1'b1, acc);
    check("flush_no_results", n_out - out_base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
